// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment codes, bit order and capture FSM states
package seg7_pkg;

    // Segment bit positions within a 7-bit code: a is the MSB, g the LSB.
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    // Hex digit n is encoded by SEG7_CODES[n], written a..g.
    localparam logic [15:0][6:0] SEG7_CODES = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // D
        7'b1001110,  // C
        7'b0011111,  // B
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } seg7_state_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        return SEG7_CODES[nibble];
    endfunction

endpackage

// File: rtl/seg7_code_to_hex.sv
// rtl/seg7_code_to_hex.sv - inverse lookup from segment pattern to nibble
module seg7_code_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] code,
    output logic       legal,
    output logic [3:0] nibble
);

    // Codes are all distinct, so at most one table entry can match.
    always_comb begin
        legal  = 1'b0;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (code == SEG7_CODES[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - recovers per-digit hex values from a multiplexed 7-segment bus
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     sel_in,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     valid_out,
    output logic                  upd_out,
    output logic [2:0]            upd_idx,
    output logic                  err_out
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam int         PAIR_W     = DIGITS + 7;

    logic [6:0]        seg_m, seg_q, seg_s;
    logic [DIGITS-1:0] sel_m, sel_q, sel_s;
    logic [PAIR_W-1:0] pair_prev;
    logic              changed;
    logic [7:0]        cnt;
    seg7_state_t       state, next_state;
    logic              do_capture;
    logic              sel_onehot;
    logic [2:0]        sel_idx;
    logic              code_legal;
    logic [3:0]        code_nibble;

    // Two-flop synchronizers for the asynchronous display pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m <= '0;
            seg_q <= '0;
            sel_m <= '0;
            sel_q <= '0;
        end else begin
            seg_m <= seg_in;
            seg_q <= seg_m;
            sel_m <= sel_in;
            sel_q <= sel_m;
        end
    end

    assign seg_s   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign sel_s   = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;
    assign changed = ({sel_s, seg_s} != pair_prev);

    // Stability counter: restarts on any bus change, saturates so a held pair fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_prev <= '0;
            cnt       <= '0;
        end else begin
            pair_prev <= {sel_s, seg_s};
            if (changed) begin
                cnt <= '0;
            end else if (cnt != STABLE_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Capture is taken on the edge where cnt reaches STABLE_CYCLES-1, which is also the CAPTURE entry.
    always_comb begin
        next_state = state;
        do_capture = 1'b0;
        case (state)
            ST_WAIT: begin
                if (!changed && cnt == STABLE_MAX - 8'd2) begin
                    do_capture = 1'b1;
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: next_state = changed ? ST_WAIT : ST_HOLD;
            ST_HOLD:    if (changed) next_state = ST_WAIT;
            default:    next_state = ST_WAIT;
        endcase
    end

    // One-hot check and index of the selected digit.
    always_comb begin
        sel_onehot = $onehot(sel_s);
        sel_idx    = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_s[i]) sel_idx = 3'(i);
        end
    end

    seg7_code_to_hex u_decode (
        .code   (seg_s),
        .legal  (code_legal),
        .nibble (code_nibble)
    );

    // Digit register file and one-cycle status pulses; blanking/overlap captures are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_out   <= '0;
            valid_out <= '0;
            upd_out   <= 1'b0;
            upd_idx   <= 3'd0;
            err_out   <= 1'b0;
        end else begin
            upd_out <= 1'b0;
            err_out <= 1'b0;
            if (do_capture && sel_onehot) begin
                upd_out <= 1'b1;
                upd_idx <= sel_idx;
                err_out <= !code_legal;
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_s[i]) begin
                        valid_out[i] <= code_legal;
                        if (code_legal) hex_out[4*i +: 4] <= code_nibble;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed self-checking bench for seg7_capture
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] hex_out;
    logic [3:0]  valid_out;
    logic        upd_out;
    logic [2:0]  upd_idx;
    logic        err_out;

    logic [6:0]  seg_n;
    logic [3:0]  sel_n;
    logic [15:0] hex_n;
    logic [3:0]  valid_n;
    logic        upd_n;
    logic [2:0]  idx_n;
    logic        err_n;

    int total = 0;
    int bad   = 0;
    int upd_seen = 0;
    int err_seen = 0;
    logic [2:0] last_idx = 3'd0;

    always #5 clk = ~clk;

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(8), .ACTIVE_LOW(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .sel_in    (sel_in),
        .hex_out   (hex_out),
        .valid_out (valid_out),
        .upd_out   (upd_out),
        .upd_idx   (upd_idx),
        .err_out   (err_out)
    );

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(8), .ACTIVE_LOW(1)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_n),
        .sel_in    (sel_n),
        .hex_out   (hex_n),
        .valid_out (valid_n),
        .upd_out   (upd_n),
        .upd_idx   (idx_n),
        .err_out   (err_n)
    );

    always @(negedge clk) begin
        if (upd_out) begin
            upd_seen <= upd_seen + 1;
            last_idx <= upd_idx;
        end
        if (err_out) err_seen <= err_seen + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
        sel_in = sel;
        seg_in = seg;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        total++; if (hex_out !== 16'h0000) begin bad++; $display("FAIL reset_hex: got %h want 0000", hex_out); end
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want 0000", valid_out); end
        total++; if (upd_out !== 1'b0) begin bad++; $display("FAIL reset_upd: got %b want 0", upd_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_out); end
        total++; if (upd_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", upd_idx); end
    endtask

    task automatic test_single();
        int u0, e0;
        u0 = upd_seen; e0 = err_seen;
        hold(4'b0010, 7'b1011011, 20);
        total++; if (upd_seen - u0 !== 1) begin bad++; $display("FAIL single_upd_count: got %0d want 1", upd_seen - u0); end
        total++; if (last_idx !== 3'd1) begin bad++; $display("FAIL single_idx: got %0d want 1", last_idx); end
        total++; if (hex_out[7:4] !== 4'h5) begin bad++; $display("FAIL single_hex: got %h want 5", hex_out[7:4]); end
        total++; if (valid_out !== 4'b0010) begin bad++; $display("FAIL single_valid: got %b want 0010", valid_out); end
        total++; if (err_seen - e0 !== 0) begin bad++; $display("FAIL single_err: got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_rotate();
        int u0, e0;
        u0 = upd_seen; e0 = err_seen;
        hold(4'b0001, 7'b1110111, 12);
        hold(4'b0010, 7'b0011111, 12);
        hold(4'b0100, 7'b1001110, 12);
        hold(4'b1000, 7'b0111101, 12);
        total++; if (hex_out !== 16'hDCBA) begin bad++; $display("FAIL rotate_hex: got %h want dcba", hex_out); end
        total++; if (valid_out !== 4'b1111) begin bad++; $display("FAIL rotate_valid: got %b want 1111", valid_out); end
        total++; if (upd_seen - u0 !== 4) begin bad++; $display("FAIL rotate_upd_count: got %0d want 4", upd_seen - u0); end
        total++; if (err_seen - e0 !== 0) begin bad++; $display("FAIL rotate_err: got %0d want 0", err_seen - e0); end
    endtask

    task automatic test_illegal();
        int u0, e0;
        hold(4'b0100, 7'b1111111, 12);
        total++; if (hex_out[11:8] !== 4'h8) begin bad++; $display("FAIL illegal_pre_hex: got %h want 8", hex_out[11:8]); end
        u0 = upd_seen; e0 = err_seen;
        hold(4'b0100, 7'b0000001, 12);
        total++; if (err_seen - e0 !== 1) begin bad++; $display("FAIL illegal_err_count: got %0d want 1", err_seen - e0); end
        total++; if (upd_seen - u0 !== 1) begin bad++; $display("FAIL illegal_upd_count: got %0d want 1", upd_seen - u0); end
        total++; if (last_idx !== 3'd2) begin bad++; $display("FAIL illegal_idx: got %0d want 2", last_idx); end
        total++; if (hex_out !== 16'hD8BA) begin bad++; $display("FAIL illegal_hex: got %h want d8ba", hex_out); end
        total++; if (valid_out !== 4'b1011) begin bad++; $display("FAIL illegal_valid: got %b want 1011", valid_out); end
    endtask

    task automatic test_glitch();
        int u0, e0;
        u0 = upd_seen; e0 = err_seen;
        for (int k = 0; k < 4; k++) begin
            hold(4'b0011, 7'b1111110, 5);
            hold(4'b0011, 7'b0110000, 5);
        end
        total++; if (upd_seen - u0 !== 0) begin bad++; $display("FAIL glitch_upd: got %0d want 0", upd_seen - u0); end
        hold(4'b0011, 7'b0110000, 20);
        total++; if (upd_seen - u0 !== 0) begin bad++; $display("FAIL overlap_upd: got %0d want 0", upd_seen - u0); end
        total++; if (err_seen - e0 !== 0) begin bad++; $display("FAIL overlap_err: got %0d want 0", err_seen - e0); end
        total++; if (hex_out !== 16'hD8BA) begin bad++; $display("FAIL overlap_hex: got %h want d8ba", hex_out); end
        total++; if (valid_out !== 4'b1011) begin bad++; $display("FAIL overlap_valid: got %b want 1011", valid_out); end
    endtask

    task automatic test_reset_mid();
        int lat;
        hold(4'b0001, 7'b1111001, 4);
        rst = 1'b1;
        step();
        total++; if (hex_out !== 16'h0000) begin bad++; $display("FAIL midrst_hex: got %h want 0000", hex_out); end
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL midrst_valid: got %b want 0000", valid_out); end
        total++; if ({upd_out, err_out} !== 2'b00) begin bad++; $display("FAIL midrst_pulses: got %b want 00", {upd_out, err_out}); end
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (upd_out === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++; if (lat !== 10) begin bad++; $display("FAIL midrst_latency: got %0d want 10", lat); end
        total++; if (hex_out[3:0] !== 4'h3) begin bad++; $display("FAIL midrst_hex0: got %h want 3", hex_out[3:0]); end
        total++; if (valid_out !== 4'b0001) begin bad++; $display("FAIL midrst_valid0: got %b want 0001", valid_out); end
    endtask

    task automatic test_active_low();
        sel_n = 4'b1110;
        seg_n = 7'b0000000;
        for (int i = 0; i < 20; i++) step();
        total++; if (hex_n[3:0] !== 4'h8) begin bad++; $display("FAIL actlow_hex: got %h want 8", hex_n[3:0]); end
        total++; if (valid_n !== 4'b0001) begin bad++; $display("FAIL actlow_valid: got %b want 0001", valid_n); end
        total++; if (idx_n !== 3'd0) begin bad++; $display("FAIL actlow_idx: got %0d want 0", idx_n); end
    endtask

    initial begin
        rst    = 1'b1;
        seg_in = 7'b0000000;
        sel_in = 4'b0000;
        seg_n  = 7'b1111111;
        sel_n  = 4'b1111;
        step(); step(); step();
        test_reset();
        rst = 1'b0;
        test_single();
        test_rotate();
        test_illegal();
        test_glitch();
        test_reset_mid();
        test_active_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
